// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// bcd_pkg : shared state encoding and digit-adjust constants for bin_to_bcd_seq
// Rev 1.0
// ============================================================================
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// bin_to_bcd_seq_if : start/busy/done handshake and data for the BCD converter
// Rev 1.0
// ============================================================================
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, output bin, input busy, input done, input bcd, input overflow);
  modport slave  (input start, input bin, output busy, output done, output bcd, output overflow);

endinterface
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// bcd_digit_adjust : one double-dabble digit correction, add 3 when digit >= 5
// Rev 1.0
// ============================================================================
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;
  end

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// bin_to_bcd_seq : sequential shift-add-3 binary to packed BCD converter
// Rev 1.0
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  wire logic           clk,
  input  wire logic           clr,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                   r_state;
  state_t                   w_state_nx;
  logic                     w_busy;
  logic [WIDTH-1:0]         r_bin;
  logic [BCD_W-1:0]         r_scratch;
  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W-1:0]         r_bcd;
  logic                     r_sticky;
  logic                     r_ovf;
  logic                     r_done;
  logic [CNT_W-1:0]         r_cnt;
  logic [BCD_W+WIDTH-1:0]   w_shift;
  logic                     w_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .din  (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .dout (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Adjusted scratch and binary shift as one register; the top bit falls into overflow.
  assign w_shift = {w_adj, r_bin} << 1;
  assign w_last  = (r_cnt == CNT_W'(1));

  always_comb begin
    w_state_nx = r_state;
    w_busy     = 1'b0;
    case (r_state)
      IDLE:    if (bus.start) w_state_nx = CONVERT;
      CONVERT: begin
        w_busy = 1'b1;
        if (w_last) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= IDLE;
    else      r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_sticky  <= 1'b0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bin     <= bus.bin;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= CNT_W'(WIDTH);
          end
        end
        CONVERT: begin
          r_bin     <= w_shift[WIDTH-1:0];
          r_scratch <= w_shift[BCD_W+WIDTH-1:WIDTH];
          r_sticky  <= r_sticky | w_adj[BCD_W-1];
          r_cnt     <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_bcd  <= w_shift[BCD_W+WIDTH-1:WIDTH];
            r_ovf  <= r_sticky | w_adj[BCD_W-1];
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_ovf;

endmodule
`default_nettype wire
